// File: rtl/sd_cmd_seq.sv
// SD-card SPI-mode command sequencer: selects the card, sends a 6-byte command
// frame with CRC7, polls for R1 and optionally releases CS via the spi engine.
module sd_cmd_seq #(
  parameter int unsigned MAX_POLL = 8
) (
  input  logic        clock50,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  cmd_idx,
  input  logic [31:0] cmd_arg,
  input  logic        keep_cs,
  output logic        busy,
  output logic        done,
  output logic [7:0]  r1,
  output logic        timeout,
  output logic        spi_sent,
  output logic [1:0]  spi_cmd,
  output logic [7:0]  spi_out,
  input  logic [7:0]  spi_din,
  input  logic [1:0]  spi_st
);

  localparam logic [1:0] SPI_TX     = 2'd1;
  localparam logic [1:0] SPI_CSLO   = 2'd2;
  localparam logic [1:0] SPI_CSHI   = 2'd3;
  localparam logic [7:0] POLL_LIMIT = 8'(MAX_POLL);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CSLO, ST_PRE, ST_FRAME, ST_POLL, ST_RELEASE, ST_TRAIL, ST_FIN
  } state_t;

  typedef enum logic [1:0] {
    PH_ISSUE, PH_ACK, PH_WAIT
  } phase_t;

  state_t      state_q, state_d;
  phase_t      phase_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [6:0]  crc_q;
  logic [5:0]  idx_q;
  logic [31:0] arg_q;
  logic        keep_q;
  logic        busy_q, done_q, timeout_q, sent_q;
  logic [7:0]  r1_q, out_q;
  logic [1:0]  cmd_q;

  logic [1:0]  op_cmd_d;
  logic [7:0]  op_out_d;
  logic        r1_hit_s, poll_to_s, finish_s;
  logic [7:0]  poll_cnt_s;
  logic        poll_end_s;
  logic        unused_s;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc_in, input logic [7:0] data);
    logic [6:0] c;
    logic       fb;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb = data[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0] sel, input logic [5:0] idx,
                                            input logic [31:0] arg, input logic [6:0] crc);
    logic [7:0] b;
    case (sel)
      3'd0:    b = {2'b01, idx};
      3'd1:    b = arg[31:24];
      3'd2:    b = arg[23:16];
      3'd3:    b = arg[15:8];
      3'd4:    b = arg[7:0];
      3'd5:    b = {crc, 1'b1};
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  assign poll_cnt_s = cnt_q + 8'd1;
  assign poll_end_s = ~spi_din[7] | (poll_cnt_s == POLL_LIMIT);
  assign unused_s   = spi_st[1];

  // Choose the next spi operation once the current one completes
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_cmd_d  = SPI_TX;
    op_out_d  = 8'hFF;
    r1_hit_s  = 1'b0;
    poll_to_s = 1'b0;
    finish_s  = 1'b0;
    case (state_q)
      ST_CSLO: begin
        state_d = ST_PRE;
      end
      ST_PRE: begin
        state_d  = ST_FRAME;
        cnt_d    = 8'd0;
        op_out_d = frame_byte(3'd0, idx_q, arg_q, crc_q);
      end
      ST_FRAME: begin
        if (cnt_q == 8'd5) begin
          state_d = ST_POLL;
          cnt_d   = 8'd0;
        end else begin
          cnt_d    = cnt_q + 8'd1;
          op_out_d = frame_byte(cnt_q[2:0] + 3'd1, idx_q, arg_q, crc_q);
        end
      end
      ST_POLL: begin
        cnt_d     = poll_cnt_s;
        r1_hit_s  = ~spi_din[7];
        poll_to_s = spi_din[7] & (poll_cnt_s == POLL_LIMIT);
        if (poll_end_s && keep_q) begin
          state_d  = ST_FIN;
          finish_s = 1'b1;
        end else if (poll_end_s) begin
          state_d  = ST_RELEASE;
          op_cmd_d = SPI_CSHI;
        end else begin
          state_d = ST_POLL;
        end
      end
      ST_RELEASE: begin
        state_d = ST_TRAIL;
      end
      ST_TRAIL: begin
        state_d  = ST_FIN;
        finish_s = 1'b1;
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // Main sequencer with the per-operation issue/ack/wait handshake
  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      phase_q   <= PH_ISSUE;
      cnt_q     <= 8'd0;
      crc_q     <= 7'd0;
      idx_q     <= 6'd0;
      arg_q     <= 32'd0;
      keep_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      r1_q      <= 8'hFF;
      timeout_q <= 1'b0;
      sent_q    <= 1'b0;
      cmd_q     <= 2'd0;
      out_q     <= 8'hFF;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            idx_q     <= cmd_idx;
            arg_q     <= cmd_arg;
            keep_q    <= keep_cs;
            busy_q    <= 1'b1;
            timeout_q <= 1'b0;
            r1_q      <= 8'hFF;
            crc_q     <= 7'd0;
            cnt_q     <= 8'd0;
            state_q   <= ST_CSLO;
            phase_q   <= PH_ISSUE;
            sent_q    <= 1'b1;
            cmd_q     <= SPI_CSLO;
            out_q     <= 8'hFF;
          end
        end
        ST_FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        ST_CSLO, ST_PRE, ST_FRAME, ST_POLL, ST_RELEASE, ST_TRAIL: begin
          case (phase_q)
            PH_ISSUE: begin
              sent_q  <= 1'b0;
              phase_q <= PH_ACK;
              // b0..b4 fold into the CRC while they are being issued; b5 carries the result
              if (state_q == ST_FRAME && cnt_q < 8'd5) begin
                crc_q <= crc7_step(crc_q, out_q);
              end
            end
            PH_ACK: begin
              if (spi_st[0]) begin
                phase_q <= PH_WAIT;
              end
            end
            PH_WAIT: begin
              if (!spi_st[0]) begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                if (r1_hit_s) begin
                  r1_q <= spi_din;
                end
                if (poll_to_s) begin
                  timeout_q <= 1'b1;
                  r1_q      <= 8'hFF;
                end
                if (finish_s) begin
                  done_q <= 1'b1;
                end else begin
                  phase_q <= PH_ISSUE;
                  sent_q  <= 1'b1;
                  cmd_q   <= op_cmd_d;
                  out_q   <= op_out_d;
                end
              end
            end
            default: begin
              phase_q <= PH_ACK;
            end
          endcase
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          sent_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign r1       = r1_q;
  assign timeout  = timeout_q;
  assign spi_sent = sent_q;
  assign spi_cmd  = cmd_q;
  assign spi_out  = out_q;

endmodule

// File: tb/tb_sd_cmd_seq.sv
// Bench for sd_cmd_seq: behavioural spi engine plus an operation-list reference
// model built from the command rules (CRC7 by polynomial long division).
module tb_sd_cmd_seq;

  localparam int MAX_POLL  = 8;
  localparam int CYC_LIMIT = 5000;

  logic        clock50 = 1'b0;
  logic        reset   = 1'b0;
  logic        start   = 1'b0;
  logic [5:0]  cmd_idx = 6'd0;
  logic [31:0] cmd_arg = 32'd0;
  logic        keep_cs = 1'b0;
  logic        busy, done, timeout, spi_sent;
  logic [7:0]  r1, spi_out;
  logic [1:0]  spi_cmd;
  logic [7:0]  spi_din;
  logic [1:0]  spi_st;

  int n_cmp = 0;
  int n_bad = 0;

  sd_cmd_seq #(.MAX_POLL(MAX_POLL)) dut (
    .clock50 (clock50),
    .reset   (reset),
    .start   (start),
    .cmd_idx (cmd_idx),
    .cmd_arg (cmd_arg),
    .keep_cs (keep_cs),
    .busy    (busy),
    .done    (done),
    .r1      (r1),
    .timeout (timeout),
    .spi_sent(spi_sent),
    .spi_cmd (spi_cmd),
    .spi_out (spi_out),
    .spi_din (spi_din),
    .spi_st  (spi_st)
  );

  always #10 clock50 = ~clock50;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // CRC7 as the remainder of msg * x^7 divided by x^7+x^3+1
  function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
    logic [46:0] rem;
    rem = {msg, 7'd0};
    for (int b = 46; b >= 7; b--) begin
      if (rem[b]) rem[b -: 8] = rem[b -: 8] ^ 8'h89;
    end
    return rem[6:0];
  endfunction

  // spi engine model: sees a spi_sent edge after 2 cycles, stays busy a random while
  int          resp_at   = -1;
  logic [7:0]  resp_byte = 8'h00;
  logic [9:0]  op_log[$];
  int          tx_since_cs = 0;
  logic        sent_d;
  int          m_state, m_ctr;
  logic [1:0]  cap_cmd;
  logic [7:0]  cap_out, m_reply;

  always @(posedge clock50 or posedge reset) begin
    if (reset) begin
      sent_d  <= 1'b0;
      m_state <= 0;
      m_ctr   <= 0;
      spi_st  <= 2'b00;
      spi_din <= 8'hFF;
      cap_cmd <= 2'd0;
      cap_out <= 8'hFF;
      m_reply <= 8'hFF;
    end else begin
      sent_d <= spi_sent;
      case (m_state)
        0: if (spi_sent && !sent_d) begin
             cap_cmd <= spi_cmd;
             cap_out <= spi_out;
             op_log.push_back({spi_cmd, (spi_cmd == 2'd1) ? spi_out : 8'h00});
             if (spi_cmd == 2'd2) tx_since_cs <= 0;
             else if (spi_cmd == 2'd1) begin
               m_reply     <= (resp_at >= 0 && tx_since_cs - 7 == resp_at) ? resp_byte : 8'hFF;
               tx_since_cs <= tx_since_cs + 1;
             end
             m_state <= 1;
           end
        1: begin
             spi_st  <= {1'($urandom_range(0, 1)), 1'b1};
             m_ctr   <= $urandom_range(2, 8);
             m_state <= 2;
           end
        2: if (m_ctr == 0) begin
             spi_st  <= 2'b00;
             spi_din <= (cap_cmd == 2'd1) ? m_reply : 8'hFF;
             m_state <= 0;
           end else begin
             m_ctr <= m_ctr - 1;
           end
        default: m_state <= 0;
      endcase
    end
  end

  int hi_run = 0;
  int lo_run = 100;
  int done_total = 0;

  always @(negedge clock50) begin
    if (!reset && m_state == 2 && m_ctr == 0) begin
      check_eq("spi_cmd_stable", 32'(spi_cmd), 32'(cap_cmd));
      check_eq("spi_out_stable", 32'(spi_out), 32'(cap_out));
    end
    if (spi_sent) begin
      if (hi_run == 0) check_eq("sent_gap_ge2", 32'(lo_run >= 2), 32'd1);
      hi_run <= hi_run + 1;
      lo_run <= 0;
    end else begin
      if (hi_run != 0) check_eq("sent_width", 32'(hi_run), 32'd1);
      hi_run <= 0;
      lo_run <= lo_run + 1;
    end
    if (done) done_total <= done_total + 1;
  end

  task automatic check_reset(input string tag);
    check_eq({tag, "_busy"},     32'(busy),     32'd0);
    check_eq({tag, "_done"},     32'(done),     32'd0);
    check_eq({tag, "_r1"},       32'(r1),       32'hFF);
    check_eq({tag, "_timeout"},  32'(timeout),  32'd0);
    check_eq({tag, "_spi_sent"}, 32'(spi_sent), 32'd0);
    check_eq({tag, "_spi_cmd"},  32'(spi_cmd),  32'd0);
    check_eq({tag, "_spi_out"},  32'(spi_out),  32'hFF);
  endtask

  // mode 1 adds ignored start pulses during FRAME and in the FIN cycle
  task automatic run_txn(input string name, input logic [5:0] idx, input logic [31:0] arg,
                         input logic keep, input int at, input logic [7:0] rb,
                         input int mode, input logic [7:0] crc_lit);
    logic [9:0]  exp_q[$];
    logic [7:0]  exp_r1;
    logic        exp_to;
    logic [39:0] msg;
    logic [6:0]  crc;
    logic [9:0]  got;
    int npoll, base, dbase, cyc;
    bit pulsed;
    base  = op_log.size();
    dbase = done_total;
    resp_at   = at;
    resp_byte = rb;
    exp_to = !(at >= 0 && at < MAX_POLL);
    npoll  = exp_to ? MAX_POLL : at + 1;
    exp_r1 = exp_to ? 8'hFF : rb;
    msg = {2'b01, idx, arg};
    crc = ref_crc7(msg);
    exp_q.push_back({2'd2, 8'h00});
    exp_q.push_back({2'd1, 8'hFF});
    for (int i = 0; i < 5; i++) exp_q.push_back({2'd1, msg[39 - 8*i -: 8]});
    exp_q.push_back({2'd1, crc, 1'b1});
    for (int i = 0; i < npoll; i++) exp_q.push_back({2'd1, 8'hFF});
    if (!keep) begin
      exp_q.push_back({2'd3, 8'h00});
      exp_q.push_back({2'd1, 8'hFF});
    end

    @(negedge clock50);
    cmd_idx = idx; cmd_arg = arg; keep_cs = keep; start = 1'b1;
    @(negedge clock50);
    start = 1'b0;
    check_eq({name, "_busy"}, 32'(busy), 32'd1);
    cmd_idx = 6'($urandom); cmd_arg = $urandom; keep_cs = ~keep;
    cyc = 0;
    pulsed = 1'b0;
    while (!done && cyc < CYC_LIMIT) begin
      @(negedge clock50);
      cyc++;
      if (mode == 1 && !pulsed && op_log.size() - base == 4) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    check_eq({name, "_done"},    32'(done),    32'd1);
    check_eq({name, "_r1"},      32'(r1),      32'(exp_r1));
    check_eq({name, "_timeout"}, 32'(timeout), 32'(exp_to));
    if (mode == 1) start = 1'b1;
    @(negedge clock50);
    start = 1'b0;
    repeat (12) @(negedge clock50);
    check_eq({name, "_idle"},     32'(busy),                32'd0);
    check_eq({name, "_done_cnt"}, 32'(done_total - dbase),  32'd1);
    check_eq({name, "_r1_held"},  32'(r1),                  32'(exp_r1));
    check_eq({name, "_to_held"},  32'(timeout),             32'(exp_to));
    check_eq({name, "_n_ops"},    32'(op_log.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base + i < op_log.size()) ? op_log[base + i] : 10'h000;
      check_eq($sformatf("%s_op%0d", name, i), 32'(got), 32'(exp_q[i]));
    end
    if (crc_lit != 8'h00) begin
      got = (base + 7 < op_log.size()) ? op_log[base + 7] : 10'h000;
      check_eq({name, "_crc_byte"}, 32'(got[7:0]), 32'(crc_lit));
    end
  endtask

  task automatic reset_mid();
    int base, cyc;
    base    = op_log.size();
    resp_at = -1;
    @(negedge clock50);
    cmd_idx = 6'd17; cmd_arg = $urandom; keep_cs = 1'b0; start = 1'b1;
    @(negedge clock50);
    start = 1'b0;
    cyc = 0;
    while (op_log.size() - base < 6 && cyc < CYC_LIMIT) begin
      @(negedge clock50);
      cyc++;
    end
    check_eq("rstmid_reached_b3", 32'(op_log.size() - base), 32'd6);
    reset = 1'b1;
    #1;
    check_reset("rstmid");
    @(negedge clock50);
    reset = 1'b0;
    repeat (20) @(negedge clock50);
    check_eq("rstmid_no_more_ops", 32'(op_log.size() - base), 32'd6);
    check_eq("rstmid_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #5 reset = 1'b1;
    #3;
    check_reset("por");
    repeat (3) @(negedge clock50);
    reset = 1'b0;
    repeat (2) @(negedge clock50);
    run_txn("cmd0",  6'd0,  32'd0,         1'b0, 1,  8'h01, 0, 8'h95);
    run_txn("cmd8",  6'd8,  32'h0000_01AA, 1'b0, 2,  8'h01, 0, 8'h87);
    run_txn("tmo",   6'd55, 32'h1234_5678, 1'b0, -1, 8'h00, 0, 8'h00);
    run_txn("cmd17", 6'd17, 32'h0000_0200, 1'b1, 0,  8'h00, 0, 8'h00);
    run_txn("ign",   6'd8,  32'h0000_01AA, 1'b0, 0,  8'h05, 1, 8'h87);
    reset_mid();
    run_txn("cmd0_after_rst", 6'd0, 32'd0, 1'b0, 0, 8'h01, 0, 8'h95);
    for (int k = 0; k < 8; k++) begin
      run_txn($sformatf("rnd%0d", k), 6'($urandom), $urandom, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 11)) - 1, 8'($urandom_range(0, 127)), 0, 8'h00);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sd_cmd_seq.md
# sd_cmd_seq

SD-card command sequencer that drives the byte-level SPI engine (`spi`) through its `spi_sent`/`spi_cmd`/`spi_out`/`spi_din`/`spi_st` interface. On one `start` pulse it performs the whole SPI-mode command transaction:

- asserts chip select;
- sends the 6-byte command frame with an internally computed CRC7;
- polls for the R1 response;
- optionally releases chip select.

It sits between the CPU-side SD controller registers and `spi`, replacing per-byte software sequencing.

## Interface
- `MAX_POLL`, default 8: maximum number of 0xFF poll bytes sent while waiting for R1 (1..255).
- `clock50`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request. Accepted only when `busy`=0.
- `cmd_idx`  in  6  command index. Latched on accepted `start`.
- `cmd_arg`  in  32  command argument. Latched on accepted `start`.
- `keep_cs`  in  1  1 = leave CS low after R1 (data phase follows). Latched on `start`.
- `busy`  out  1  transaction in progress.
- `done`  out  1  one-cycle pulse at end of transaction.
- `r1`  out  8  R1 response. Holds its value until the next `start`.
- `timeout`  out  1  no R1 within `MAX_POLL` bytes. Valid with `done`, held until the next `start`.
- `spi_sent`  out  1  request strobe to `spi` (rising edge starts an operation).
- `spi_cmd`  out  2  operation to `spi`: 1 = transmit, 2 = CS low, 3 = CS high.
- `spi_out`  out  8  byte to transmit.
- `spi_din`  in  8  byte received by `spi`.
- `spi_st`  in  2  bit0 = `spi` busy. Bit1 is ignored.

## Operation
- **Reset values:** `busy`=0, `done`=0, `r1`=8'hFF, `timeout`=0, `spi_sent`=0, `spi_cmd`=0, `spi_out`=8'hFF. FSM goes to IDLE, CRC is cleared, byte counter is cleared.
- **SPI handshake (sub-FSM used for every `spi` operation):**
  - ISSUE: drive `spi_cmd`/`spi_out`, `spi_sent`=1 for exactly one cycle.
  - ACK: `spi_sent`=0; wait for `spi_st[0]`=1.
  - WAIT: wait for `spi_st[0]`=0.
  - The operation is complete on the cycle `spi_st[0]`=0 is sampled in WAIT.
  - `spi_cmd`/`spi_out` stay stable from ISSUE until completion.
  - `spi_sent` is low for at least 2 cycles between pulses.
- **Main FSM:**
  - IDLE: on `start`, latch inputs, set `busy`=1, clear `timeout`, set `r1`=FF, CRC=0, go to CSLO.
  - CSLO: op `spi_cmd`=2, then go to PRE.
  - PRE: transmit 0xFF, then go to FRAME with counter=0.
  - FRAME: transmit frame byte[counter], counter 0..5, then go to POLL with counter=0. Frame bytes:
    - b0 = {2'b01, cmd_idx};
    - b1..b4 = `cmd_arg`[31:24], [23:16], [15:8], [7:0];
    - b5 = {crc7, 1'b1}.
  - POLL: transmit 0xFF, counter+1, then evaluate `spi_din`:
    - `spi_din`[7]=0: `r1`=`spi_din`, go to RELEASE.
    - Otherwise, if counter=`MAX_POLL`: `timeout`=1, `r1`=8'hFF, go to RELEASE.
    - Otherwise stay in POLL.
  - RELEASE:
    - `keep_cs`=1: go to FIN with CS left low.
    - `keep_cs`=0: op `spi_cmd`=3, then TRAIL.
  - TRAIL: transmit 0xFF (8 release clocks), then go to FIN.
  - FIN: `done`=1 for one cycle, `busy`=0, go to IDLE.
- **CRC7:**
  - Polynomial x^7+x^3+1, MSB first, initial value 0.
  - Updated by an 8-bit parallel step with each of b0..b4 at its ISSUE cycle.
  - b5 uses the result after b4.
- **Boundary rules:**
  - `start` while `busy`=1 is ignored; latched values do not change.
  - `start` in the FIN cycle is ignored. `start` is accepted from the next cycle on (IDLE).
  - `reset` mid-transaction returns all outputs to their reset values immediately. It does not issue CS high; software re-selects.
  - POLL counter is 8 bits and never wraps, because `MAX_POLL` ≤ 255.

## Timing
- `spi` needs 2 cycles to see a `spi_sent` edge, so ACK normally lasts 2–3 cycles.
- One transmit costs about 64 cycles in `spi` plus 4 cycles of handshake overhead.
- CS ops cost about 3 cycles in `spi` plus overhead.
- Minimum transaction (R1 on the first poll, `keep_cs`=0) = 1 CSLO + 1 PRE + 6 FRAME + 1 POLL + 1 CSHI + 1 TRAIL = 9 transmits + 2 CS ops, about 640 cycles.
- `done` rises 1 cycle after completion of the last operation.
- `r1` and `timeout` are valid in the same cycle as `done`.

## Test plan
- **CMD0:** `cmd_idx`=0, `cmd_arg`=0, `keep_cs`=0. The `spi` model returns 0xFF then 0x01.
  - Transmitted bytes: FF 40 00 00 00 00 95 FF FF FF.
  - `r1`=0x01, `timeout`=0, CS low then high, one `done` pulse.
- **CMD8:** `cmd_idx`=8, `cmd_arg`=0x000001AA.
  - Frame is 48 00 00 01 AA 87.
  - Model returns 0x01 on the 3rd poll: exactly 3 poll bytes, `r1`=0x01.
- **Timeout:** model always returns 0xFF, `MAX_POLL`=8.
  - Exactly 8 poll bytes, `timeout`=1, `r1`=0xFF, CS released, TRAIL byte sent.
- **CMD17 with `keep_cs`=1:** `cmd_arg`=0x00000200, model returns 0x00.
  - `r1`=0x00, no `spi_cmd`=3 issued, no TRAIL byte, `done` after the POLL completion.
- **Ignored start:** second `start` pulses during FRAME and in the FIN cycle.
  - Both ignored, the first transaction's bytes are unchanged, and only one `done` pulse.
- **Reset mid-transaction:** `reset` pulse during FRAME byte 3.
  - All outputs take reset values asynchronously.
  - A new CMD0 `start` afterwards completes correctly with CRC 0x95.
